// File: rtl/eth_pcs_params.sv
// Shared 10GBASE-R PCS constants and types used by the RX-side blocks.
package eth_pcs_params;

  localparam int W_DATA_DFLT     = 32;
  localparam int SH_CNT_MAX_DFLT = 64;
  localparam int SH_INV_MAX_DFLT = 16;
  localparam int SLIP_WAIT_DFLT  = 32;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {RESET_CNT, TEST_SH, SLIP, SLIP_WAIT} blk_sync_state_t;

  function automatic logic sh_is_valid(input logic [1:0] h);
    return (h == SYNC_DATA) || (h == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_pcs_block_sync.sv
// 64b/66b RX block lock: tests sync headers per window, requests bit slips
// until aligned, and forwards header/payload one cycle later.
module eth_pcs_block_sync #(
  parameter int W_DATA     = eth_pcs_params::W_DATA_DFLT,
  parameter int SH_CNT_MAX = eth_pcs_params::SH_CNT_MAX_DFLT,
  parameter int SH_INV_MAX = eth_pcs_params::SH_INV_MAX_DFLT,
  parameter int SLIP_WAIT  = eth_pcs_params::SLIP_WAIT_DFLT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clk_en,
  input  logic [1:0]        i_hdr,
  input  logic              i_hdr_valid,
  input  logic [W_DATA-1:0] i_data,
  output logic [1:0]        o_hdr,
  output logic              o_hdr_valid,
  output logic [W_DATA-1:0] o_data,
  output logic              o_block_lock,
  output logic              o_slip
);
  import eth_pcs_params::*;

  localparam int CW = $clog2(SH_CNT_MAX + 1);
  localparam int IW = $clog2(SH_INV_MAX + 1);
  localparam int WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  // The state literal shares its name with the wait-length parameter.
  localparam blk_sync_state_t ST_WAIT = eth_pcs_params::SLIP_WAIT;

  blk_sync_state_t state, state_nxt;
  logic [CW-1:0] sh_cnt, cnt_nxt;
  logic [IW-1:0] sh_inv_cnt, inv_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          lock_nxt, slip_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = sh_cnt;
    inv_nxt   = sh_inv_cnt;
    wait_nxt  = wait_cnt;
    lock_nxt  = o_block_lock;
    slip_nxt  = 1'b0;
    case (state)
      RESET_CNT: begin
        cnt_nxt   = '0;
        inv_nxt   = '0;
        state_nxt = TEST_SH;
      end
      TEST_SH: begin
        if (i_hdr_valid) begin
          cnt_nxt = sh_cnt + CW'(1);
          if (sh_is_valid(i_hdr)) begin
            if (cnt_nxt == CW'(SH_CNT_MAX)) begin
              if (sh_inv_cnt == '0) lock_nxt = 1'b1;
              state_nxt = RESET_CNT;
            end
          end else begin
            inv_nxt = sh_inv_cnt + IW'(1);
            // Loss of lock takes priority over a window that ends on the same header.
            if (!o_block_lock || inv_nxt == IW'(SH_INV_MAX)) begin
              state_nxt = SLIP;
              lock_nxt  = 1'b0;
            end else if (cnt_nxt == CW'(SH_CNT_MAX)) begin
              state_nxt = RESET_CNT;
            end
          end
        end
      end
      SLIP: begin
        lock_nxt  = 1'b0;
        slip_nxt  = 1'b1;
        wait_nxt  = '0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == WW'(SLIP_WAIT - 1)) state_nxt = RESET_CNT;
        else                                wait_nxt  = wait_cnt + WW'(1);
      end
      default: state_nxt = RESET_CNT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= RESET_CNT;
      sh_cnt       <= '0;
      sh_inv_cnt   <= '0;
      wait_cnt     <= '0;
      o_block_lock <= 1'b0;
      o_slip       <= 1'b0;
      o_hdr        <= '0;
      o_hdr_valid  <= 1'b0;
      o_data       <= '0;
    end else if (i_clk_en) begin
      state        <= state_nxt;
      sh_cnt       <= cnt_nxt;
      sh_inv_cnt   <= inv_nxt;
      wait_cnt     <= wait_nxt;
      o_block_lock <= lock_nxt;
      o_slip       <= slip_nxt;
      o_hdr        <= i_hdr;
      o_hdr_valid  <= i_hdr_valid;
      o_data       <= i_data;
    end
  end

endmodule

// File: tb/tb_eth_pcs_block_sync.sv
// Directed bench for eth_pcs_block_sync: acquisition, slip/wait, lock hold/loss,
// clock-enable gating and asynchronous reset.
module tb_eth_pcs_block_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [1:0]  hdr;
  logic        hdr_valid;
  logic [31:0] data;
  logic [1:0]  o_hdr;
  logic        o_hdr_valid;
  logic [31:0] o_data;
  logic        o_block_lock;
  logic        o_slip;

  int total = 0;
  int bad   = 0;
  int slip_rises = 0;
  logic prev_slip = 1'b0;

  always #5 clk = ~clk;

  eth_pcs_block_sync dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_clk_en     (clk_en),
    .i_hdr        (hdr),
    .i_hdr_valid  (hdr_valid),
    .i_data       (data),
    .o_hdr        (o_hdr),
    .o_hdr_valid  (o_hdr_valid),
    .o_data       (o_data),
    .o_block_lock (o_block_lock),
    .o_slip       (o_slip)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic cyc(input logic [1:0] h, input logic v, input logic e, input logic [31:0] d);
    hdr = h; hdr_valid = v; clk_en = e; data = d;
    @(posedge clk);
    #1;
    if (o_slip && !prev_slip) slip_rises++;
    prev_slip = o_slip;
  endtask

  function automatic logic [1:0] alt_hdr(input int i);
    return (i % 2 == 0) ? 2'b01 : 2'b10;
  endfunction

  initial begin
    rst = 1'b1; clk_en = 1'b0; hdr = 2'b00; hdr_valid = 1'b0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lock",  {31'b0, o_block_lock}, 32'd0);
    chk("rst_slip",  {31'b0, o_slip},       32'd0);
    chk("rst_hvld",  {31'b0, o_hdr_valid},  32'd0);
    chk("rst_hdr",   {30'b0, o_hdr},        32'd0);
    chk("rst_data",  o_data,                32'd0);
    rst = 1'b0;

    // Unlocked: four good headers, then 2'b00 on block 5.
    cyc(2'b00, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(alt_hdr(i), 1'b1, 1'b1, 32'hA500_0000 | i);
      if (i == 0) begin
        chk("dp_hdr",  {30'b0, o_hdr},       32'd1);
        chk("dp_hvld", {31'b0, o_hdr_valid}, 32'd1);
        chk("dp_data", o_data,               32'hA500_0000);
      end
    end
    cyc(2'b00, 1'b1, 1'b1, 32'h0);
    chk("b5_lock", {31'b0, o_block_lock}, 32'd0);
    chk("b5_noslip_yet", {31'b0, o_slip}, 32'd0);
    cyc(2'b01, 1'b1, 1'b1, 32'h0);
    chk("b5_slip", {31'b0, o_slip}, 32'd1);
    // 32 wait cycles + 1 counter-clear cycle: bad headers here must be ignored.
    for (int i = 0; i < 33; i++) begin
      cyc(2'b00, 1'b1, 1'b1, 32'h0);
      if (i == 0) chk("b5_slip_end", {31'b0, o_slip}, 32'd0);
    end
    chk("b5_one_slip", slip_rises, 32'd1);
    for (int i = 0; i < 64; i++) begin
      cyc(alt_hdr(i), 1'b1, 1'b1, 32'h0);
      if (i == 62) chk("acq_lock_63", {31'b0, o_block_lock}, 32'd0);
    end
    chk("acq_lock_64", {31'b0, o_block_lock}, 32'd1);

    // Locked: 15 invalid headers in a window keep lock.
    cyc(2'b00, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 64; i++) begin
      cyc((i % 4 == 3 && i < 60) ? 2'b11 : alt_hdr(i), 1'b1, 1'b1, 32'h0);
      if (i == 59) chk("inv15_mid_lock", {31'b0, o_block_lock}, 32'd1);
    end
    chk("inv15_lock", {31'b0, o_block_lock}, 32'd1);
    chk("inv15_noslip", slip_rises, 32'd1);
    cyc(2'b00, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 64; i++) cyc(alt_hdr(i), 1'b1, 1'b1, 32'h0);
    chk("win2_lock", {31'b0, o_block_lock}, 32'd1);

    // Locked: 16th invalid header drops lock, slip follows one cycle later.
    cyc(2'b00, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 31; i++) begin
      cyc((i % 2 == 0) ? 2'b00 : 2'b10, 1'b1, 1'b1, 32'h0);
      if (i == 28) chk("inv16_lock_15", {31'b0, o_block_lock}, 32'd1);
    end
    chk("inv16_lock", {31'b0, o_block_lock}, 32'd0);
    chk("inv16_noslip_yet", {31'b0, o_slip}, 32'd0);
    cyc(2'b01, 1'b1, 1'b1, 32'h0);
    chk("inv16_slip", {31'b0, o_slip}, 32'd1);
    cyc(2'b01, 1'b1, 1'b0, 32'h0);
    chk("slip_held_en0", {31'b0, o_slip}, 32'd1);
    cyc(2'b01, 1'b1, 1'b1, 32'h1234_5678);
    chk("slip_drop", {31'b0, o_slip}, 32'd0);
    chk("two_slips", slip_rises, 32'd2);
    for (int i = 0; i < 5; i++) cyc(2'b10, 1'b1, 1'b1, 32'h1234_5678);

    // Asynchronous reset in the middle of the slip wait.
    #2 rst = 1'b1;
    #1;
    chk("arst_lock", {31'b0, o_block_lock}, 32'd0);
    chk("arst_slip", {31'b0, o_slip},       32'd0);
    chk("arst_hvld", {31'b0, o_hdr_valid},  32'd0);
    chk("arst_hdr",  {30'b0, o_hdr},        32'd0);
    chk("arst_data", o_data,                32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Relock with clock enable toggling; disabled cycles carry junk.
    cyc(2'b00, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 64; i++) begin
      cyc(alt_hdr(i), 1'b1, 1'b1, 32'hC000_0000 | i);
      if (i == 62) chk("en_lock_63", {31'b0, o_block_lock}, 32'd0);
      cyc(2'b00, 1'b1, 1'b0, 32'hDEAD_BEEF);
      if (i == 0) begin
        chk("en0_hdr_held",  {30'b0, o_hdr}, 32'd1);
        chk("en0_data_held", o_data,         32'hC000_0000);
      end
    end
    chk("en_lock_64", {31'b0, o_block_lock}, 32'd1);
    chk("en_noslip", slip_rises, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
